// File: rtl/spart_rx.sv
// Receive half of the mini SPART: 16x-oversampled 8N1 deserializer with
// rda/clr_rda handshake, framing-error and overrun flags.
`timescale 1ns/1ps
module spart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SAMPLE_PT  = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 RxD,
  input  logic                 clr_rda,
  output logic [DATA_BITS-1:0] data,
  output logic                 rda,
  output logic                 ferr,
  output logic                 oerr
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [BW-1:0]          bcnt_reg, bcnt_next;
  logic [DATA_BITS-1:0]   sh_reg, sh_next;
  logic                   meta_reg, rxs_reg;
  logic                   done;
  logic [DATA_BITS-1:0]   data_reg;
  logic                   rda_reg, ferr_reg, oerr_reg;

  // RxD is asynchronous to clk; two flops before any decision is made on it
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= 1'b1;
      rxs_reg  <= 1'b1;
    end else begin
      meta_reg <= RxD;
      rxs_reg  <= meta_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bcnt_reg  <= '0;
      sh_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bcnt_reg  <= bcnt_next;
      sh_reg    <= sh_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bcnt_next  = bcnt_reg;
    sh_next    = sh_reg;
    done       = 1'b0;
    if (en) begin
      case (state_reg)
        IDLE: begin
          if (!rxs_reg) begin
            state_next = START;
            cnt_next   = '0;
          end
        end
        START: begin
          if (cnt_reg == CW'(SAMPLE_PT)) begin
            if (!rxs_reg) begin
              state_next = DATA;
              cnt_next   = '0;
              bcnt_next  = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        DATA: begin
          if (cnt_reg == CW'(OVERSAMPLE - 1)) begin
            sh_next  = {rxs_reg, sh_reg[DATA_BITS-1:1]};
            cnt_next = '0;
            if (bcnt_reg == BW'(DATA_BITS - 1)) state_next = STOP;
            else                                bcnt_next  = bcnt_reg + BW'(1);
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        STOP: begin
          // Leave at the stop midpoint so a back-to-back start edge is not missed
          if (cnt_reg == CW'(OVERSAMPLE - 1)) begin
            done       = 1'b1;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // A completing frame takes priority over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= '0;
      rda_reg  <= 1'b0;
      ferr_reg <= 1'b0;
      oerr_reg <= 1'b0;
    end else if (done) begin
      data_reg <= sh_reg;
      rda_reg  <= 1'b1;
      ferr_reg <= ~rxs_reg;
      if (clr_rda)      oerr_reg <= 1'b0;
      else if (rda_reg) oerr_reg <= 1'b1;
    end else if (clr_rda) begin
      rda_reg  <= 1'b0;
      ferr_reg <= 1'b0;
      oerr_reg <= 1'b0;
    end
  end

  assign data = data_reg;
  assign rda  = rda_reg;
  assign ferr = ferr_reg;
  assign oerr = oerr_reg;

endmodule
